aes_job_arbiter: RTL and testbench
==================================

# aes_job_arbiter

Shares one AES datapath (Encryption and Decryption cores, Nk/Nr parameterised) among NREQ requesters, such as multiple SPI slave front-ends. It selects one pending job by round-robin, drives the job's block, key and mode into the engine, and waits a fixed settle time. It then captures the result and returns it with the requester's ID over a valid/ready response channel. The engine is instantiated outside this block; this block only sequences it.

## Interface
- NREQ, 4: number of requesters, 2..8
- Nk, 4: key length in 32-bit words (4/6/8)
- Nr, 10: round count, passed through to the engine instance
- LATENCY, 2: settle cycles allowed for the combinational engine, ≥1
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester job pending
- req_ready  out  NREQ  one-hot grant/accept, at most one bit high
- req_mode  in  NREQ  per requester: 1 = encrypt, 0 = decrypt
- req_data  in  128*NREQ  requester i block at [128*i +: 128]
- req_key  in  32*Nk*NREQ  requester i key at [32*Nk*i +: 32*Nk]
- eng_data  out  128  registered block to engine
- eng_key  out  32*Nk  registered key to engine
- eng_mode  out  1  registered mode (selects result mux)
- eng_enc  in  128  engine encryption result
- eng_dec  in  128  engine decryption result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  clog2(NREQ)  index of the requester that owns rsp_data
- rsp_data  out  128  result block
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - If any req_valid bit is set, the rr_arbiter picks the first set bit at or after the pointer `ptr`, wrapping around.
  - req_ready[g] is driven high combinationally for the granted requester g only.
  - Handshake (req_valid[g] & req_ready[g]) latches req_data/req_key/req_mode of g into eng_*, stores g as the job ID, sets ptr ← (g+1) mod NREQ, loads cnt ← LATENCY, and moves to WAIT.
- **WAIT**
  - Decrement cnt each cycle. req_ready is all-zero.
  - When cnt==1: latch rsp_data ← eng_mode ? eng_enc : eng_dec, set rsp_id, move to RESP.
- **RESP**
  - rsp_valid=1. rsp_data and rsp_id are held stable until rsp_ready.
  - On handshake, return to IDLE. A new grant is not possible in that same cycle.
- Rules:
  - req_valid may drop before a grant; this creates no obligation.
  - Requests are not required to be sticky.
  - eng_* hold the last job's values after completion.

## Timing
- Reset (rst==0 at a posedge) has these effects:
  - State goes to IDLE; ptr=0; cnt=0.
  - eng_data=0, eng_key=0, eng_mode=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req_ready is all-zero during the reset cycle.
- Reset mid-job aborts the job with no response, including in WAIT or RESP with a pending result.
- Request handshake in cycle t: WAIT occupies cycles t+1..t+LATENCY; rsp_valid first goes high in cycle t+LATENCY+1.
- With rsp_ready held high, throughput is one job per LATENCY+2 cycles.
- Simultaneous requests: only the granted one sees req_ready. The others wait and win in rotation, so there is no starvation. Worst-case wait is NREQ-1 jobs.
- Pointer wrap: granting NREQ-1 sets ptr=0.
- rsp_ready held low: the FSM stays in RESP indefinitely, with no new grants and req_ready all-zero.

## Structure
- Shared package `aes_pkg` contains:
  - BLOCK_W=128
  - key-width function KEY_W(Nk)=32*Nk
  - ID width function clog2
  - the state enum {IDLE, WAIT, RESP}
- Sub-module `rr_arbiter`: combinational inputs req[NREQ] and ptr; outputs one-hot grant and the encoded index. Reusable by other shared-engine controllers.
- Top level contains the FSM, the counter, the eng_*/rsp_* registers and the result mux.

## Test plan
- AES-128 encrypt: requester 0 sends mode=1, key 000102…0e0f, pt 00112233445566778899aabbccddeeff → rsp_id=0, rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, exactly LATENCY+1 cycles after the accept cycle.
- Decrypt: requester 2 sends mode=0 with the same key and ct 69c4e0d86a7b0430d8cdb78070b4c55a → rsp_id=2, rsp_data 00112233445566778899aabbccddeeff.
- Fairness: NREQ=4, all req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0,1; req_ready is one-hot or zero every cycle.
- Backpressure: hold rsp_ready=0 for 20 cycles in RESP → rsp_data/rsp_id stable, req_ready=0; release → single handshake, then IDLE.
- Reset mid-WAIT: drive rst=0 for one cycle in WAIT → next cycle all outputs at reset values, no rsp_valid; the following job from requester 3 is granted with ptr restarted at 0.
- AES-256 (Nk=8, Nr=14): key 000102…1e1f, pt 00112233…eeff → ct 8ea2b7ca516745bfeafc49904b496089.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and width helpers for controllers that sequence an external AES engine.
package aes_pkg;

  localparam int BLOCK_W = 128;

  // Key width in bits for a key of nk 32-bit words.
  function automatic int KEY_W(input int nk);
    return 32 * nk;
  endfunction

  // Ceiling log2, never below 1 so it can size an index or counter port.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter
  import aes_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        grant,
  output logic [clog2(NREQ)-1:0] idx,
  output logic                   any
);

  localparam int IDW = clog2(NREQ);

  int             slot;
  logic [IDW-1:0] slot_idx;

  // Scan NREQ slots starting at ptr; the first pending one wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    slot     = 0;
    slot_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      slot     = (int'(ptr) + k) % NREQ;
      slot_idx = IDW'(slot);
      if (!any && req[slot_idx]) begin
        any             = 1'b1;
        grant[slot_idx] = 1'b1;
        idx             = slot_idx;
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one external combinational AES engine among NREQ requesters:
// round-robin grant, drive the engine, wait LATENCY cycles, return the result.
module aes_job_arbiter
  import aes_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int Nk      = 4,
  parameter int Nr      = 10,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_mode,
  input  logic [BLOCK_W*NREQ-1:0]    req_data,
  input  logic [KEY_W(Nk)*NREQ-1:0]  req_key,
  output logic [BLOCK_W-1:0]         eng_data,
  output logic [KEY_W(Nk)-1:0]       eng_key,
  output logic                       eng_mode,
  input  logic [BLOCK_W-1:0]         eng_enc,
  input  logic [BLOCK_W-1:0]         eng_dec,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [clog2(NREQ)-1:0]     rsp_id,
  output logic [BLOCK_W-1:0]         rsp_data,
  output logic                       busy
);

  localparam int IDW    = clog2(NREQ);
  localparam int KW     = KEY_W(Nk);
  // A zero settle time would never reach the capture point, so clamp to one cycle.
  localparam int SETTLE = (LATENCY < 1) ? 1 : LATENCY;
  localparam int CW     = clog2(SETTLE + 1);

  // The round count belongs to the engine instance; a non-standard Nk/Nr pairing
  // is tolerated and only marked in the elaborated hierarchy.
  generate
    if (Nr != Nk + 6) begin : g_nonstandard_rounds
    end
  endgenerate

  state_t         state_reg, state_next;
  logic [IDW-1:0] ptr_reg;
  logic [CW-1:0]  cnt_reg;
  logic [IDW-1:0] job_id_reg;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic           accept;
  logic           capture;

  logic [BLOCK_W-1:0] data_arr [NREQ];
  logic [KW-1:0]      key_arr  [NREQ];

  // Split the flat request buses into per-requester words.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[BLOCK_W*gi +: BLOCK_W];
      assign key_arr[gi]  = req_key[KW*gi +: KW];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next state, grant strobe and capture strobe; nothing is granted under reset.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = grant;
        if (grant_any) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == CW'(1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!rst) begin
      req_ready = '0;
      accept    = 1'b0;
      capture   = 1'b0;
    end
  end

  // Job latch into the engine, settle counter, pointer rotation and result capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      job_id_reg <= '0;
      eng_data   <= '0;
      eng_key    <= '0;
      eng_mode   <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        eng_data   <= data_arr[grant_idx];
        eng_key    <= key_arr[grant_idx];
        eng_mode   <= req_mode[grant_idx];
        job_id_reg <= grant_idx;
        ptr_reg    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        cnt_reg    <= CW'(SETTLE);
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - CW'(1);
      end
      if (capture) begin
        rsp_data <= eng_mode ? eng_enc : eng_dec;
        rsp_id   <= job_id_reg;
      end
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    rsp_valid = (state_reg == RESP);
    busy      = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Scoreboard bench for aes_job_arbiter with a behavioural stand-in for the AES engine.
module tb_aes_job_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ENC_SALT = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
  localparam logic [127:0] DEC_SALT = 128'h3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c;

  // Engine stand-in: exact FIPS-197 answers for the known vectors, a keyed scramble otherwise.
  function automatic logic [127:0] enc128(input logic [127:0] d, input logic [127:0] k);
    if (k == K128 && d == PT) return CT128;
    return d ^ k ^ ENC_SALT;
  endfunction
  function automatic logic [127:0] dec128(input logic [127:0] d, input logic [127:0] k);
    if (k == K128 && d == CT128) return PT;
    return d ^ k ^ DEC_SALT;
  endfunction
  function automatic logic [127:0] enc256(input logic [127:0] d, input logic [255:0] k);
    if (k == K256 && d == PT) return CT256;
    return d ^ k[127:0] ^ k[255:128] ^ ENC_SALT;
  endfunction
  function automatic logic [127:0] dec256(input logic [127:0] d, input logic [255:0] k);
    if (k == K256 && d == CT256) return PT;
    return d ^ k[127:0] ^ k[255:128] ^ DEC_SALT;
  endfunction

  typedef struct packed {
    logic [1:0]   id;
    logic [127:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       req_valid, req_ready, req_mode;
  logic [511:0]     req_data, req_key;
  logic [127:0]     rq_data [4];
  logic [127:0]     rq_key  [4];
  logic [127:0]     eng_data, eng_key, eng_enc, eng_dec, rsp_data;
  logic             eng_mode, rsp_valid, rsp_ready, busy;
  logic [1:0]       rsp_id;

  logic [3:0]       b_req_valid, b_req_ready, b_req_mode;
  logic [511:0]     b_req_data;
  logic [1023:0]    b_req_key;
  logic [127:0]     b_rq_data [4];
  logic [255:0]     b_rq_key  [4];
  logic [127:0]     b_eng_data, b_eng_enc, b_eng_dec, b_rsp_data;
  logic [255:0]     b_eng_key;
  logic             b_eng_mode, b_rsp_valid, b_busy;
  logic [1:0]       b_rsp_id;

  assign req_data   = {rq_data[3], rq_data[2], rq_data[1], rq_data[0]};
  assign req_key    = {rq_key[3], rq_key[2], rq_key[1], rq_key[0]};
  assign b_req_data = {b_rq_data[3], b_rq_data[2], b_rq_data[1], b_rq_data[0]};
  assign b_req_key  = {b_rq_key[3], b_rq_key[2], b_rq_key[1], b_rq_key[0]};

  assign eng_enc   = enc128(eng_data, eng_key);
  assign eng_dec   = dec128(eng_data, eng_key);
  assign b_eng_enc = enc256(b_eng_data, b_eng_key);
  assign b_eng_dec = dec256(b_eng_data, b_eng_key);

  aes_job_arbiter #(.NREQ(NREQ), .Nk(4), .Nr(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_data(req_data), .req_key(req_key),
    .eng_data(eng_data), .eng_key(eng_key), .eng_mode(eng_mode),
    .eng_enc(eng_enc), .eng_dec(eng_dec), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  aes_job_arbiter #(.NREQ(NREQ), .Nk(8), .Nr(14), .LATENCY(LAT)) u_dut256 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_mode(b_req_mode), .req_data(b_req_data), .req_key(b_req_key),
    .eng_data(b_eng_data), .eng_key(b_eng_key), .eng_mode(b_eng_mode),
    .eng_enc(b_eng_enc), .eng_dec(b_eng_dec), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .busy(b_busy)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  exp_t exp_q256[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   cyc = 0;
  int   onehot_bad = 0;
  int   mon_idx;
  exp_t mon_e;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    if (busy) check({name, "_idle_timeout"}, 128'(busy), 128'(0));
  endtask

  // Monitor: logs grants, enforces one-hot req_ready, pops the scoreboard on each response handshake.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (!$onehot0(req_ready) || (req_ready & ~req_valid) != 4'b0) onehot_bad++;
      if (|(req_valid & req_ready)) begin
        mon_idx = 0;
        for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) mon_idx = i;
        grant_log.push_back(mon_idx);
        grant_cyc.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 128'(rsp_valid), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          $display("rsp  id=%0d data=%h (want id=%0d data=%h)", rsp_id, rsp_data, mon_e.id, mon_e.data);
          check("rsp_id", 128'(rsp_id), 128'(mon_e.id));
          check("rsp_data", rsp_data, mon_e.data);
        end
      end
      if (b_rsp_valid && rsp_ready) begin
        if (exp_q256.size() == 0) begin
          check("unexpected_rsp256", 128'(b_rsp_valid), 128'(0));
        end else begin
          mon_e = exp_q256.pop_front();
          $display("rsp256 id=%0d data=%h (want id=%0d data=%h)", b_rsp_id, b_rsp_data, mon_e.id, mon_e.data);
          check("rsp256_id", 128'(b_rsp_id), 128'(mon_e.id));
          check("rsp256_data", b_rsp_data, mon_e.data);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int want_order [6];
    logic [127:0] held_data;
    logic [1:0]   held_id;
    int stable_bad;

    want_order = '{0, 1, 2, 3, 0, 1};
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_mode = '0;
    b_req_valid = '0;
    b_req_mode = '0;
    for (int i = 0; i < 4; i++) begin
      rq_data[i] = '0; rq_key[i] = '0; b_rq_data[i] = '0; b_rq_key[i] = '0;
    end

    // Reset state, with a request pending that must not be granted.
    repeat (2) @(negedge clk);
    check("reset_req_ready", 128'(req_ready), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset_eng_data", eng_data, 128'(0));
    check("reset_eng_key", eng_key, 128'(0));
    check("reset_eng_mode", 128'(eng_mode), 128'(0));
    check("reset_rsp_id", 128'(rsp_id), 128'(0));
    check("reset_rsp_data", rsp_data, 128'(0));
    edge_drive();
    rst = 1'b1;
    req_valid = 4'b0000;

    // AES-128 encrypt from requester 0, with latency measurement.
    edge_drive();
    rq_data[0] = PT; rq_key[0] = K128; req_mode[0] = 1'b1;
    exp_q.push_back('{id: 2'd0, data: CT128});
    req_valid = 4'b0001;
    @(negedge clk);
    check("enc_req_ready", 128'(req_ready), 128'(4'b0001));
    edge_drive();
    req_valid = 4'b0000;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("enc_eng_data", eng_data, PT);
        check("enc_eng_key", eng_key, K128);
        check("enc_eng_mode", 128'(eng_mode), 128'(1));
        check("enc_busy", 128'(busy), 128'(1));
      end
    end while (!rsp_valid && lat < 20);
    check("enc_latency", 128'(lat), 128'(LAT + 1));
    wait_idle("enc");

    // Decrypt from requester 2.
    edge_drive();
    rq_data[2] = CT128; rq_key[2] = K128; req_mode[2] = 1'b0;
    exp_q.push_back('{id: 2'd2, data: PT});
    req_valid = 4'b0100;
    @(negedge clk);
    check("dec_req_ready", 128'(req_ready), 128'(4'b0100));
    edge_drive();
    req_valid = 4'b0000;
    wait_idle("dec");

    // Reset during WAIT aborts the job from requester 1.
    edge_drive();
    rq_data[1] = 128'hdeadbeef_00000000_cafef00d_11111111;
    rq_key[1]  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    req_mode[1] = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("abort_req_ready", 128'(req_ready), 128'(4'b0010));
    edge_drive();
    req_valid = 4'b0000;
    rst = 1'b0;
    @(negedge clk);
    check("abort_rst_req_ready", 128'(req_ready), 128'(0));
    edge_drive();
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_rsp_valid", 128'(rsp_valid), 128'(0));
    check("abort_eng_data", eng_data, 128'(0));
    check("abort_eng_key", eng_key, 128'(0));
    check("abort_eng_mode", 128'(eng_mode), 128'(0));
    repeat (4) @(negedge clk);
    check("abort_no_rsp", 128'(rsp_valid), 128'(0));

    // Requester 3 after the reset; its grant wraps the pointer back to 0.
    edge_drive();
    rq_data[3] = 128'h0123456789abcdeffedcba9876543210;
    rq_key[3]  = 128'h13579bdf02468ace13579bdf02468ace;
    req_mode[3] = 1'b0;
    exp_q.push_back('{id: 2'd3, data: dec128(rq_data[3], rq_key[3])});
    req_valid = 4'b1000;
    @(negedge clk);
    check("r3_req_ready", 128'(req_ready), 128'(4'b1000));
    edge_drive();
    req_valid = 4'b0000;
    wait_idle("r3");

    // Fairness: all requesters pending, rsp_ready high.
    edge_drive();
    rq_data[0] = PT;    rq_key[0] = K128; req_mode[0] = 1'b1;
    rq_data[1] = CT128; rq_key[1] = K128; req_mode[1] = 1'b0;
    rq_data[2] = 128'hffeeddccbbaa99887766554433221100;
    rq_key[2]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    req_mode[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      case (want_order[i])
        0: exp_q.push_back('{id: 2'd0, data: CT128});
        1: exp_q.push_back('{id: 2'd1, data: PT});
        2: exp_q.push_back('{id: 2'd2, data: enc128(rq_data[2], rq_key[2])});
        default: exp_q.push_back('{id: 2'd3, data: dec128(rq_data[3], rq_key[3])});
      endcase
    end
    grant_log.delete();
    grant_cyc.delete();
    req_valid = 4'b1111;
    lat = 0;
    do begin
      @(negedge clk);
      #1;
      lat++;
    end while (grant_log.size() < 6 && lat < 60);
    edge_drive();
    req_valid = 4'b0000;
    wait_idle("fair");
    for (int i = 0; i < 6; i++)
      check($sformatf("fair_grant%0d", i), 128'((i < grant_log.size()) ? grant_log[i] : -1), 128'(want_order[i]));
    for (int i = 1; i < 6; i++)
      check($sformatf("fair_period%0d", i),
            128'((i < grant_cyc.size()) ? grant_cyc[i] - grant_cyc[i-1] : -1), 128'(LAT + 2));

    // Backpressure: response held for 20 cycles while others wait.
    edge_drive();
    rsp_ready = 1'b0;
    rq_data[2] = 128'h00000000000000000000000000000001;
    rq_key[2]  = 128'h80000000000000000000000000000000;
    req_mode[2] = 1'b1;
    exp_q.push_back('{id: 2'd2, data: enc128(rq_data[2], rq_key[2])});
    req_valid = 4'b0100;
    edge_drive();
    req_valid = 4'b1011;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    check("bp_rsp_valid", 128'(rsp_valid), 128'(1));
    held_data = rsp_data;
    held_id = rsp_id;
    stable_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_data !== held_data || rsp_id !== held_id || req_ready !== 4'b0 || rsp_valid !== 1'b1)
        stable_bad++;
    end
    check("bp_stable", 128'(stable_bad), 128'(0));
    check("bp_held_data", held_data, enc128(rq_data[2], rq_key[2]));
    edge_drive();
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("bp_after_busy", 128'(busy), 128'(0));
    check("bp_after_rsp_valid", 128'(rsp_valid), 128'(0));
    check("bp_queue_drained", 128'(exp_q.size()), 128'(0));

    // AES-256 instance, encrypt from requester 0.
    edge_drive();
    b_rq_data[0] = PT; b_rq_key[0] = K256; b_req_mode[0] = 1'b1;
    exp_q256.push_back('{id: 2'd0, data: CT256});
    b_req_valid = 4'b0001;
    @(negedge clk);
    check("aes256_req_ready", 128'(b_req_ready), 128'(4'b0001));
    edge_drive();
    b_req_valid = 4'b0000;
    @(negedge clk);
    check("aes256_eng_mode", 128'(b_eng_mode), 128'(1));
    lat = 0;
    while (b_busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("aes256_done", 128'(b_busy), 128'(0));

    check("onehot_req_ready", 128'(onehot_bad), 128'(0));
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    check("queue256_empty", 128'(exp_q256.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
